// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execution unit (alu_op classes, funct3, op enum, FSM states)
package exec_pkg;
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ZERO
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  function automatic logic is_shift(op_e op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/exec_unit_alu_decoder.sv
// alu_decoder: maps {alu_op, funct3, funct7[5]} to the internal op
module alu_decoder
  import exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output op_e        op
);
  always_comb begin
    op = OP_ZERO;
    if (alu_op == ALU_OP_ADD) op = OP_ADD;
    else if (alu_op == ALU_OP_SUB) op = OP_SUB;
    else if (alu_op == ALU_OP_RTYPE)
      case (funct3)
        F3_ADD:  op = funct7_5 ? OP_SUB : OP_ADD;
        F3_SLL:  op = OP_SLL;
        F3_SLT:  op = OP_SLT;
        F3_SLTU: op = OP_SLTU;
        F3_XOR:  op = OP_XOR;
        F3_SR:   op = funct7_5 ? OP_SRA : OP_SRL;
        F3_OR:   op = OP_OR;
        default: op = OP_AND;
      endcase
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue ALU with a bit-serial shifter and valid/ready handshakes
module exec_unit
  import exec_pkg::*;
#(
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                alu_op,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic [REG_DATA_WIDTH-1:0] src_a,
  input  logic [REG_DATA_WIDTH-1:0] src_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      zero
);
  localparam int W = REG_DATA_WIDTH;
  state_e         r_state, w_next;
  op_e            r_op, w_op;
  logic [4:0]     r_cnt;
  logic [W-1:0]   r_result, w_alu, w_shifted;
  logic           r_zero, w_accept, w_shift_op;
  alu_decoder u_dec (.alu_op(alu_op), .funct3(funct3), .funct7_5(funct7[5]), .op(w_op));
  assign w_accept   = r_state == ST_IDLE && in_valid;
  assign w_shift_op = is_shift(w_op) && src_b[4:0] != 5'd0;
  // Shift ops pass src_a through; the shifting itself happens one bit per cycle in ST_SHIFT.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = src_a + src_b;
      OP_SUB:  w_alu = src_a - src_b;
      OP_SLT:  w_alu = {{(W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: w_alu = {{(W-1){1'b0}}, src_a < src_b};
      OP_XOR:  w_alu = src_a ^ src_b;
      OP_OR:   w_alu = src_a | src_b;
      OP_AND:  w_alu = src_a & src_b;
      OP_SLL, OP_SRL, OP_SRA: w_alu = src_a;
      default: w_alu = '0;
    endcase
  end
  assign w_shifted = r_op == OP_SLL ? {r_result[W-2:0], 1'b0}
                                    : {r_op == OP_SRA && r_result[W-1], r_result[W-1:1]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_accept ? (w_shift_op ? ST_SHIFT : ST_DONE) : ST_IDLE;
      ST_SHIFT: w_next = r_cnt == 5'd1 ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next = out_ready ? ST_IDLE : ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ZERO;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= w_op;
        r_cnt    <= w_shift_op ? src_b[4:0] : 5'd0;
        r_result <= w_alu;
        r_zero   <= w_alu == '0;
      end else if (r_state == ST_SHIFT) begin
        r_cnt    <= r_cnt - 5'd1;
        r_result <= w_shifted;
        r_zero   <= w_shifted == '0;
      end
    end
  end
  assign in_ready  = r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign result    = r_result;
  assign zero      = r_zero;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard-driven self-checking bench for exec_unit
module tb_exec_unit;
  logic        clk = 1'b0, nreset = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, zero;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_chk = 0, n_fail = 0;
  exec_unit #(.REG_DATA_WIDTH(32)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready before accept", {31'd0, in_ready}, 32'd1);
    alu_op = op; funct3 = f3; funct7 = f7; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    alu_op = 2'b11; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input int hold);
    int cyc;
    logic [31:0] e;
    int l;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    drive(op, f3, f7, a, b);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1 cyc++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " latency"}, cyc, l);
    check({tag, " result"}, result, e);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, " held valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " held result"}, result, e);
      check({tag, " held in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check({tag, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask
  initial begin
    int seen;
    #12;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    @(negedge clk) nreset = 1'b1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    run("add wrap", 2'b00, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run("sub cls", 2'b01, 3'b111, 7'h00, 32'd10, 32'd3, 32'd7, 1, 0);
    run("rtype sub", 2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
    run("rtype add", 2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 1, 0);
    run("slt", 2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
    run("sltu", 2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run("xor", 2'b10, 3'b100, 7'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 2);
    run("or", 2'b10, 3'b110, 7'h00, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1, 0);
    run("and", 2'b10, 3'b111, 7'h00, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
    run("reserved", 2'b11, 3'b000, 7'h00, 32'd9, 32'd9, 32'd0, 1, 0);
    run("sra", 2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 0);
    run("srl", 2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000, 5, 0);
    run("sll backpressure", 2'b10, 3'b001, 7'h00, 32'd1, 32'd31, 32'h8000_0000, 32, 10);
    run("sll shamt0", 2'b10, 3'b001, 7'h00, 32'h1234_5678, 32'h20, 32'h1234_5678, 1, 0);
    drive(2'b10, 3'b001, 7'h00, 32'd1, 32'd31);
    repeat (3) @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset result", result, 32'd0);
    check("midreset zero", {31'd0, zero}, 32'd1);
    @(negedge clk) nreset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midreset no result", seen, 0);
    check("midreset idle", {31'd0, in_ready}, 32'd1);
    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
